// File: rtl/ecall_pkg.sv
// Shared types and constants for the ECALL control stage.
package ecall_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FIRE,
    ST_WAIT,
    ST_WB,
    ST_REDIRECT,
    ST_HALT
  } ecall_state_e;

  localparam logic [4:0]  REG_A0               = 5'd10;
  localparam int unsigned DEFAULT_EXIT_SYSCALL = 93;
  localparam int unsigned NUM_ARGS             = 8;

endpackage

// File: rtl/ecall_arg_snapshot.sv
// Eight-entry argument register bank (a0..a7) with load enable and sync reset.
module ecall_arg_snapshot
  import ecall_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load,
  input  logic [NUM_ARGS-1:0][DATA_WIDTH-1:0]  din,
  output logic [NUM_ARGS-1:0][DATA_WIDTH-1:0]  dout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ecall_sequencer.sv
// Freezes the pipeline around an ECALL, hands a0..a7 to the ecall block,
// writes the result back to x10, then redirects fetch or halts.
module ecall_sequencer
  import ecall_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned EXIT_SYSCALL = DEFAULT_EXIT_SYSCALL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ecall_valid,
  input  logic [ADDR_WIDTH-1:0] ecall_pc,
  input  logic                  pipe_empty,
  input  logic                  store_pending,
  input  logic [DATA_WIDTH-1:0] rf_a0,
  input  logic [DATA_WIDTH-1:0] rf_a1,
  input  logic [DATA_WIDTH-1:0] rf_a2,
  input  logic [DATA_WIDTH-1:0] rf_a3,
  input  logic [DATA_WIDTH-1:0] rf_a4,
  input  logic [DATA_WIDTH-1:0] rf_a5,
  input  logic [DATA_WIDTH-1:0] rf_a6,
  input  logic [DATA_WIDTH-1:0] rf_a7,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] a0_,
  output logic                  trigger,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [DATA_WIDTH-1:0] a1,
  output logic [DATA_WIDTH-1:0] a2,
  output logic [DATA_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0] a4,
  output logic [DATA_WIDTH-1:0] a5,
  output logic [DATA_WIDTH-1:0] a6,
  output logic [DATA_WIDTH-1:0] a7,
  output logic                  stall,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halt,
  output logic [31:0]           ecall_count
);

  ecall_state_e state, next_state;

  logic [ADDR_WIDTH-1:0]                pc_q;
  logic [DATA_WIDTH-1:0]                result_q;
  logic [ADDR_WIDTH-1:0]                redirect_pc_q;
  logic [31:0]                          count_q;
  logic                                 snap_load;
  logic                                 is_exit;
  logic [NUM_ARGS-1:0][DATA_WIDTH-1:0]  rf_args;
  logic [NUM_ARGS-1:0][DATA_WIDTH-1:0]  snap_args;

  assign rf_args = {rf_a7, rf_a6, rf_a5, rf_a4, rf_a3, rf_a2, rf_a1, rf_a0};

  ecall_arg_snapshot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_snapshot (
    .clk   (clk),
    .reset (reset),
    .load  (snap_load),
    .din   (rf_args),
    .dout  (snap_args)
  );

  // Exit decision uses the snapshot, not the live register file.
  assign is_exit = (snap_args[7] == DATA_WIDTH'(EXIT_SYSCALL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      pc_q          <= '0;
      result_q      <= '0;
      redirect_pc_q <= '0;
      count_q       <= '0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && ecall_valid) begin
        pc_q <= ecall_pc;
      end
      if (state == ST_WAIT && flush) begin
        result_q <= a0_;
      end
      if (state == ST_WB) begin
        count_q <= count_q + 32'd1;
        if (!is_exit) begin
          redirect_pc_q <= pc_q + ADDR_WIDTH'(4);
        end
      end
    end
  end

  always_comb begin
    next_state     = state;
    trigger        = 1'b0;
    stall          = 1'b1;
    rf_we          = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    snap_load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        stall = 1'b0;
        if (ecall_valid) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_empty && !store_pending) begin
          snap_load  = 1'b1;
          next_state = ST_FIRE;
        end
      end
      ST_FIRE: begin
        trigger    = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) next_state = ST_WB;
      end
      ST_WB: begin
        rf_we      = 1'b1;
        next_state = is_exit ? ST_HALT : ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        next_state     = ST_IDLE;
      end
      ST_HALT: begin
        halt = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign rf_waddr    = REG_A0;
  assign rf_wdata    = result_q;
  assign redirect_pc = redirect_pc_q;
  assign ecall_count = count_q;

  assign a0 = snap_args[0];
  assign a1 = snap_args[1];
  assign a2 = snap_args[2];
  assign a3 = snap_args[3];
  assign a4 = snap_args[4];
  assign a5 = snap_args[5];
  assign a6 = snap_args[6];
  assign a7 = snap_args[7];

endmodule

// File: tb/tb_ecall_sequencer.sv
// Directed bench for ecall_sequencer: per-cycle comparison against a
// transaction-level model plus hand-computed expectations per scenario.
module tb_ecall_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ecall_valid, pipe_empty, store_pending, flush;
  logic [63:0] ecall_pc, res_in;
  logic [63:0] rf [8];
  logic        trigger, stall, rf_we, redirect_valid, halt;
  logic [63:0] a_out [8];
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata, redirect_pc;
  logic [31:0] ecall_count;

  int checks = 0;
  int fails  = 0;
  bit started = 1'b0;

  ecall_sequencer #(
    .DATA_WIDTH   (64),
    .ADDR_WIDTH   (64),
    .EXIT_SYSCALL (93)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ecall_valid    (ecall_valid),
    .ecall_pc       (ecall_pc),
    .pipe_empty     (pipe_empty),
    .store_pending  (store_pending),
    .rf_a0          (rf[0]),
    .rf_a1          (rf[1]),
    .rf_a2          (rf[2]),
    .rf_a3          (rf[3]),
    .rf_a4          (rf[4]),
    .rf_a5          (rf[5]),
    .rf_a6          (rf[6]),
    .rf_a7          (rf[7]),
    .flush          (flush),
    .a0_            (res_in),
    .trigger        (trigger),
    .a0             (a_out[0]),
    .a1             (a_out[1]),
    .a2             (a_out[2]),
    .a3             (a_out[3]),
    .a4             (a_out[4]),
    .a5             (a_out[5]),
    .a6             (a_out[6]),
    .a7             (a_out[7]),
    .stall          (stall),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .ecall_count    (ecall_count)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: which step of the ECALL protocol is active in the current cycle.
  bit          m_drain, m_trig, m_wait, m_wb, m_redir, m_halt;
  bit          n_drain, n_trig, n_wait, n_wb, n_redir;
  logic [63:0] m_pc, m_res;
  logic [63:0] m_args [8];
  logic [31:0] m_count;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      {m_drain, m_trig, m_wait, m_wb, m_redir, m_halt} = '0;
      m_pc = '0; m_res = '0; m_count = '0;
      for (int i = 0; i < 8; i++) m_args[i] = '0;
    end else begin
      {n_drain, n_trig, n_wait, n_wb, n_redir} = '0;
      if (!(m_drain | m_trig | m_wait | m_wb | m_redir | m_halt) && ecall_valid) begin
        m_pc = ecall_pc;
        n_drain = 1'b1;
      end
      if (m_drain) begin
        if (pipe_empty && !store_pending) begin
          for (int i = 0; i < 8; i++) m_args[i] = rf[i];
          n_trig = 1'b1;
        end else n_drain = 1'b1;
      end
      if (m_trig) n_wait = 1'b1;
      if (m_wait) begin
        if (flush) begin
          m_res = res_in;
          n_wb = 1'b1;
        end else n_wait = 1'b1;
      end
      if (m_wb) begin
        m_count = m_count + 1;
        if (m_args[7] == 64'd93) m_halt = 1'b1;
        else n_redir = 1'b1;
      end
      {m_drain, m_trig, m_wait, m_wb, m_redir} = {n_drain, n_trig, n_wait, n_wb, n_redir};
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("trigger", trigger, m_trig);
      check("stall", stall, m_drain | m_trig | m_wait | m_wb | m_redir | m_halt);
      check("rf_we", rf_we, m_wb);
      check("redirect_valid", redirect_valid, m_redir);
      check("halt", halt, m_halt);
      check("ecall_count", ecall_count, m_count);
      for (int i = 0; i < 8; i++) check($sformatf("a%0d", i), a_out[i], m_args[i]);
      if (m_wb) begin
        check("rf_waddr", rf_waddr, 10);
        check("rf_wdata", rf_wdata, m_res);
      end
      if (m_redir) check("redirect_pc", redirect_pc, m_pc + 64'd4);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end of stimulus required $finish");
    $fatal(1);
  end

  task automatic set_args(input logic [63:0] base, input logic [63:0] a7v);
    for (int i = 0; i < 7; i++) rf[i] = base + 64'(i);
    rf[7] = a7v;
  endtask

  // Minimum-latency ECALL starting in an IDLE cycle; ends in the IDLE cycle after REDIRECT.
  task automatic do_ecall(input logic [63:0] pc, input logic [63:0] res, input logic [63:0] exp_rpc);
    ecall_valid = 1'b1; ecall_pc = pc;
    tick();
    ecall_valid = 1'b0;
    tick();
    check("do_trigger", trigger, 1);
    tick();
    flush = 1'b1; res_in = res;
    tick();
    flush = 1'b0;
    check("do_rf_we", rf_we, 1);
    check("do_rf_wdata", rf_wdata, res);
    tick();
    check("do_redirect_valid", redirect_valid, 1);
    check("do_redirect_pc", redirect_pc, exp_rpc);
    tick();
  endtask

  // From a FIRE cycle: flush in the first WAIT cycle, run through to IDLE.
  task automatic complete_from_fire(input logic [63:0] res);
    tick();
    flush = 1'b1; res_in = res;
    tick();
    flush = 1'b0;
    tick();
    tick();
  endtask

  int we_seen, rd_seen;

  initial begin
    reset = 1'b1; ecall_valid = 1'b0; ecall_pc = '0; pipe_empty = 1'b1;
    store_pending = 1'b0; flush = 1'b0; res_in = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    tick(); tick();
    check("rst_stall", stall, 0);
    check("rst_trigger", trigger, 0);
    check("rst_halt", halt, 0);
    check("rst_count", ecall_count, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    reset = 1'b0;
    tick();

    // Basic: flush during FIRE must be ignored, flush in WAIT is taken.
    set_args(64'h100, 64'd64);
    ecall_valid = 1'b1; ecall_pc = 64'h1000;
    tick();
    ecall_valid = 1'b0;
    check("basic_c1_stall", stall, 1);
    check("basic_c1_trigger", trigger, 0);
    tick();
    check("basic_c2_trigger", trigger, 1);
    check("basic_c2_a7", a_out[7], 64);
    flush = 1'b1; res_in = 64'hBAD;
    tick();
    check("basic_c3_trigger", trigger, 0);
    flush = 1'b1; res_in = 64'hD;
    tick();
    flush = 1'b0;
    check("basic_c4_rf_we", rf_we, 1);
    check("basic_c4_rf_wdata", rf_wdata, 64'hD);
    check("basic_c4_rf_waddr", rf_waddr, 10);
    check("basic_c4_redirect", redirect_valid, 0);
    tick();
    check("basic_c5_redirect", redirect_valid, 1);
    check("basic_c5_redirect_pc", redirect_pc, 64'h1004);
    check("basic_c5_count", ecall_count, 1);
    check("basic_c5_rf_we", rf_we, 0);
    tick();
    check("basic_c6_stall", stall, 0);

    // Drain hold: store_pending during cycles 1..7, trigger lands at cycle 9.
    set_args(64'h200, 64'd5);
    ecall_valid = 1'b1; ecall_pc = 64'h2000; store_pending = 1'b1;
    tick();
    ecall_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check("drain_stall", stall, 1);
      check("drain_trigger", trigger, 0);
      rf[0] = 64'h300 + 64'(c);
      tick();
    end
    store_pending = 1'b0; rf[0] = 64'hABC; rf[3] = 64'hDEF;
    check("drain_c8_trigger", trigger, 0);
    check("drain_c8_stall", stall, 1);
    tick();
    rf[0] = 64'h999;
    check("drain_c9_trigger", trigger, 1);
    check("drain_c9_a0", a_out[0], 64'hABC);
    check("drain_c9_a3", a_out[3], 64'hDEF);
    complete_from_fire(64'h55);
    check("drain_count", ecall_count, 2);

    // Reset one cycle after trigger; a late flush must not write back.
    set_args(64'h400, 64'd1);
    ecall_valid = 1'b1; ecall_pc = 64'h3000;
    tick();
    ecall_valid = 1'b0;
    tick();
    check("rstw_trigger", trigger, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b1; res_in = 64'h77;
    check("rstw_stall", stall, 0);
    check("rstw_trigger0", trigger, 0);
    check("rstw_rf_we", rf_we, 0);
    check("rstw_redirect", redirect_valid, 0);
    check("rstw_count", ecall_count, 0);
    check("rstw_a7", a_out[7], 0);
    check("rstw_rf_wdata", rf_wdata, 0);
    tick();
    flush = 1'b0;
    check("rstw_late_flush_we", rf_we, 0);
    tick();
    check("rstw_late_flush_we2", rf_we, 0);
    do_ecall(64'h4000, 64'h99, 64'h4004);
    check("rstw_fresh_count", ecall_count, 1);

    // Back-to-back: ecall_valid in WAIT ignored, ecall_valid after REDIRECT taken.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    set_args(64'h500, 64'd0);
    ecall_valid = 1'b1; ecall_pc = 64'h5000;
    tick();
    ecall_valid = 1'b0;
    tick();
    tick();
    ecall_valid = 1'b1; ecall_pc = 64'h6000;
    tick();
    ecall_valid = 1'b0; flush = 1'b1; res_in = 64'h11;
    tick();
    flush = 1'b0;
    check("b2b_rf_wdata", rf_wdata, 64'h11);
    tick();
    check("b2b_redirect_pc", redirect_pc, 64'h5004);
    tick();
    check("b2b_idle_stall", stall, 0);
    ecall_valid = 1'b1; ecall_pc = 64'h7000;
    tick();
    ecall_valid = 1'b0;
    check("b2b_accept_stall", stall, 1);
    tick();
    check("b2b_trigger", trigger, 1);
    complete_from_fire(64'h22);
    check("b2b_count", ecall_count, 2);

    // PC wrap.
    do_ecall(64'hFFFF_FFFF_FFFF_FFFC, 64'h33, 64'h0);
    check("wrap_count", ecall_count, 3);

    // Exit syscall: one write-back, then halted until reset.
    set_args(64'h800, 64'd93);
    ecall_valid = 1'b1; ecall_pc = 64'h8000;
    tick();
    ecall_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1; res_in = 64'h0;
    tick();
    flush = 1'b0;
    check("exit_rf_we", rf_we, 1);
    we_seen = 0; rd_seen = 0;
    for (int i = 0; i < 100; i++) begin
      ecall_valid = (i % 10 == 3);
      tick();
      if (rf_we) we_seen++;
      if (redirect_valid) rd_seen++;
    end
    ecall_valid = 1'b0;
    check("exit_extra_we", 64'(we_seen), 0);
    check("exit_redirects", 64'(rd_seen), 0);
    check("exit_halt", halt, 1);
    check("exit_stall", stall, 1);
    check("exit_count", ecall_count, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("exit_reset_halt", halt, 0);
    check("exit_reset_stall", stall, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ecall_sequencer.md
# ecall_sequencer

Control stage directly upstream of the `ecall` block. It catches an ECALL retiring from writeback, freezes the pipeline, and waits for in-flight work and pending stores to drain. It then snapshots a0–a7, fires a one-cycle `trigger` into `ecall`, captures the returned a0 and writes it back to x10. Finally it redirects fetch to `pc + 4`, or halts the core on an exit syscall.

## Interface
- `DATA_WIDTH`, 64, register/data width
- `ADDR_WIDTH`, 64, PC width
- `EXIT_SYSCALL`, 93, a7 value that halts instead of redirecting
- `clk` in 1 system clock
- `reset` in 1 synchronous, active-high; one clock, all state sampled on `posedge clk`
- `ecall_valid` in 1 ECALL retiring from writeback this cycle
- `ecall_pc` in ADDR_WIDTH PC of that ECALL
- `pipe_empty` in 1 no younger instruction in flight past decode
- `store_pending` in 1 D-cache/write buffer has uncommitted stores
- `rf_a0`..`rf_a7` in DATA_WIDTH live register-file values of x10..x17
- `flush` in 1 from `ecall`; result-ready pulse
- `a0_` in DATA_WIDTH from `ecall`; result, valid when `flush`=1
- `trigger` out 1 to `ecall`, one-cycle pulse
- `a0`..`a7` out DATA_WIDTH to `ecall`, registered snapshot
- `stall` out 1 freeze fetch/decode/issue
- `rf_we` out 1 register-file write enable
- `rf_waddr` out 5 write address, constant 10 when `rf_we`=1
- `rf_wdata` out DATA_WIDTH write data
- `redirect_valid` out 1 one-cycle fetch redirect
- `redirect_pc` out ADDR_WIDTH redirect target
- `halt` out 1 sticky until reset
- `ecall_count` out 32 completed ECALLs, wraps at 2^32

## Operation
- FSM: IDLE → DRAIN → FIRE → WAIT → WB → (REDIRECT | HALT).
- IDLE:
  - `ecall_valid`=1 latches `ecall_pc`, asserts `stall` next cycle, goes to DRAIN.
  - `ecall_valid` in any other state is ignored.
- DRAIN: stays while `pipe_empty`=0 or `store_pending`=1. When both clear, latches `rf_a0..a7` into `a0..a7` and goes to FIRE.
- FIRE: `trigger`=1 for exactly one cycle, then WAIT.
- WAIT: holds until `flush`=1, with no timeout. On flush, captures `a0_` and goes to WB.
- WB: `rf_we`=1, `rf_waddr`=10, `rf_wdata`=captured result, for one cycle. `ecall_count`++.
  - If snapshot a7 == EXIT_SYSCALL, go to HALT.
  - Otherwise go to REDIRECT.
- REDIRECT: `redirect_valid`=1, `redirect_pc`=latched pc + 4 (mod 2^ADDR_WIDTH), then IDLE.
- HALT: `halt`=1 and `stall`=1 forever; only `reset` exits.
- `stall`=1 in every state except IDLE.
- `flush` outside WAIT is ignored.
- A `flush` arriving in the same cycle `trigger` is high is ignored, because `ecall` registers its response.

## Timing
- Reset values: state IDLE; `trigger`, `stall`, `rf_we`, `redirect_valid`, `halt` = 0; `a0..a7`, `rf_wdata`, `redirect_pc` = 0; `ecall_count` = 0.
- `reset` mid-operation returns to IDLE next edge. A `trigger` in flight is abandoned and any later `flush` is ignored.
- Minimum latency, `ecall_valid` to `redirect_valid`: 5 cycles, with drain satisfied on entry and `flush` one cycle after `trigger`.
  - Cycle 0: `ecall_valid`.
  - Cycle 1: DRAIN.
  - Cycle 2: FIRE.
  - Cycle 3: WAIT, `flush` seen.
  - Cycle 4: WB.
  - Cycle 5: REDIRECT.
- `a0..a7` are stable from FIRE until the next DRAIN exit.
- `rf_we` and `redirect_valid` are never high in the same cycle.

## Structure
- Shared package `ecall_pkg`:
  - `ecall_state_e` enum.
  - `REG_A0 = 5'd10`.
  - `EXIT_SYSCALL` default.
- Sub-module `ecall_arg_snapshot`: 8×DATA_WIDTH register bank with load enable and sync reset.
- The top instantiates `ecall_sequencer` feeding `ecall`.

## Test plan
- Basic: `ecall_valid`, `ecall_pc`=0x1000, drain clear, a7=64, `a0_`=0xD → `trigger` at cycle 2; `rf_we` with `rf_wdata`=0xD at cycle 4; `redirect_pc`=0x1004 at cycle 5; `ecall_count`=1.
- Drain hold: `store_pending` high for 7 cycles → `trigger` delayed exactly 7 cycles, `stall` continuous. `a0..a7` equal the `rf` values in the cycle drain clears, not the values at entry.
- Exit: a7=93 → `rf_we` once, no `redirect_valid`, `halt` and `stall` stay 1 for 100 cycles; `ecall_valid` pulses are ignored.
- Reset in WAIT: `reset` 1 cycle after `trigger` → all outputs at reset values. A late `flush` produces no `rf_we`, and a fresh ECALL then completes normally.
- Back-to-back: a second `ecall_valid` during WAIT is ignored. A new `ecall_valid` the cycle after REDIRECT is accepted, and `ecall_count` reaches 2.
- Wrap: `ecall_pc`=2^64−4 → `redirect_pc`=0.
